hilo_muldiv: RTL

Parametrised HI/LO register pair with an attached iterative multiply/divide engine for the multicycle CPU datapath. Successor to the plain HI/LO latch: HI and LO are true clocked registers, written either directly (MTHI/MTLO) or by a multi-cycle signed/unsigned multiply or divide, with a busy/done handshake toward the control FSM. Sits beside the ALU; outputs feed the MFHI/MFLO result mux.

---
 rtl/hilo_muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 41 ++++
 rtl/hilo_muldiv.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_pkg.sv
// rtl/hilo_muldiv_pkg.sv - shared opcode and FSM state types for the HI/LO multiply/divide unit
//
// Purpose : types shared by hilo_muldiv, muldiv_step and their bench.
// Contents: op_t   - operation codes driven on hilo_muldiv.op
//           state_t - iteration FSM states

package hilo_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 multiply (shift-add) or divide (restoring shift-subtract) iteration
//
// Purpose : purely combinational single-iteration datapath.
// Ports   : is_div  - 1 = divide step, 0 = multiply step
//           acc_in  - 2*WIDTH working register
//                     multiply: {partial product high, remaining multiplier bits}
//                     divide  : {partial remainder, remaining dividend / quotient bits}
//           opnd    - multiplicand magnitude (multiply) or divisor magnitude (divide)
//           acc_out - working register after this iteration

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                   is_div,
    input  logic [2*WIDTH-1:0]     acc_in,
    input  logic [WIDTH-1:0]       opnd,
    output logic [2*WIDTH-1:0]     acc_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] cand;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: add multiplicand into the high half when the current
        // multiplier LSB is set, then shift right with the carry coming in on top.
        sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
        // Divide: shift the next dividend bit into the WIDTH+1 bit partial remainder.
        cand = acc_in[2*WIDTH-1:WIDTH-1];
        diff = cand - {1'b0, opnd};

        if (!is_div) begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end else if (cand >= {1'b0, opnd}) begin
            acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_out = {cand[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with iterative signed/unsigned multiply/divide
//
// Purpose : HI/LO registers written by MTHI/MTLO or by a WIDTH+2 cycle
//           multiply/divide; busy/done handshake to the control FSM.
// Ports   : clk, rst_n (async, active-low)
//           start, op, a, b - request, sampled only in IDLE
//           busy            - arithmetic op in flight
//           done            - one-cycle pulse, hi/lo hold the new result
//           hi, lo          - HI and LO registers

module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    logic               is_div_q,  is_div_d;
    logic               neg_q,     neg_d;      // negate product / quotient
    logic               neg_rem_q, neg_rem_d;  // negate remainder (sign of a)
    logic               div0_q,    div0_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] step_out;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .opnd    (opnd_q),
        .acc_out (step_out)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // Magnitudes are WIDTH-bit unsigned, so |MIN| = 2^(WIDTH-1) fits.
        is_signed = (op == MULT) || (op == DIV);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        prod = neg_q ? -acc_q : acc_q;
        quot = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        MTHI: hi_d = a;
                        MTLO: lo_d = a;
                        MULT, MULTU: begin
                            acc_d    = {{WIDTH{1'b0}}, b_mag};
                            opnd_d   = a_mag;
                            is_div_d = 1'b0;
                            neg_d    = a_neg ^ b_neg;
                            div0_d   = 1'b0;
                            cnt_d    = CW'(WIDTH - 1);
                            busy_d   = 1'b1;
                            state_d  = CALC;
                        end
                        DIV, DIVU: begin
                            acc_d     = {{WIDTH{1'b0}}, a_mag};
                            opnd_d    = b_mag;
                            is_div_d  = 1'b1;
                            neg_d     = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            div0_d    = (b == '0);
                            cnt_d     = CW'(WIDTH - 1);
                            busy_d    = 1'b1;
                            state_d   = CALC;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                acc_d = step_out;
                if (cnt_q == '0) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIN: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else begin
                    // With a zero divisor the restoring loop yields all-ones
                    // quotient and |a| remainder; the quotient is never negated.
                    lo_d = (neg_q && !div0_q) ? -quot : quot;
                    hi_d = neg_rem_q ? -rem : rem;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
